alu_sp_seq: RTL

- Multi-cycle sequencer for the 8-bit single-purpose ALU (alu_sp).
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 4x8 register file.
- Drives the ALU op/operand ports, captures the ALU result and writes it back.
- Sits between the instruction source (testbench or fetch unit) and the combinational ALU instance.

---
 rtl/alu_sp_pkg.sv | 38 +++
 rtl/alu_sp_regfile.sv | 43 ++++
 rtl/alu_sp_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_sp_pkg.sv
// ============================================================================
// alu_sp_pkg : shared opcodes, instruction fields and FSM states for alu_sp_seq
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_sp_pkg;

  localparam int ALU_DW = 8;

  localparam logic [2:0] OP_MOV   = 3'b000;
  localparam logic [2:0] OP_LOADI = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;

  localparam int INSTR_W = 16;
  localparam int OP_LSB  = 13;
  localparam int RD_LSB  = 11;
  localparam int RA_LSB  = 9;
  localparam int RB_LSB  = 0;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // 110 and 111 are the only reserved encodings
  function automatic logic op_reserved(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sp_regfile.sv
// ============================================================================
// alu_sp_regfile : NREG x DW register file, one sync write, three comb reads
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_sp_regfile #(
  parameter  int NREG = 4,
  parameter  int DW   = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [RW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [RW-1:0] i_ra,
  input  logic [RW-1:0] i_rb,
  input  logic [RW-1:0] i_dbg_sel,
  output logic [DW-1:0] o_rdata_a,
  output logic [DW-1:0] o_rdata_b,
  output logic [DW-1:0] o_dbg_data
);

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_ra];
  assign o_rdata_b  = r_mem[i_rb];
  assign o_dbg_data = r_mem[i_dbg_sel];

endmodule

`default_nettype wire

// File: rtl/alu_sp_seq.sv
// ============================================================================
// alu_sp_seq : 3-cycle sequencer driving the external alu_sp combinational ALU
// Optional flags outputs under `ALU_SP_SEQ_FLAGS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module alu_sp_seq
  import alu_sp_pkg::*;
#(
  parameter  int NREG = 4,
  parameter  int DW   = ALU_DW,
  localparam int RW   = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DW-1:0]      alu_op,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  input  logic [DW-1:0]      alu_res,
  output logic               done,
  output logic               err,
  input  logic [RW-1:0]      dbg_sel,
  output logic [DW-1:0]      dbg_data
`ifdef ALU_SP_SEQ_FLAGS_EN
  ,
  output logic               zero_flag,
  output logic               carry_flag
`endif
);

  state_t             r_state;
  state_t             w_next;
  logic [INSTR_W-1:0] r_ir;

  logic [2:0]    w_op;
  logic [RW-1:0] w_rd;
  logic [RW-1:0] w_ra;
  logic [RW-1:0] w_rb;
  logic [DW-1:0] w_imm;
  logic [DW-1:0] w_rdata_a;
  logic [DW-1:0] w_rdata_b;
  logic          w_we;
  logic          w_unused;

  assign w_op     = r_ir[OP_LSB +: 3];
  assign w_rd     = r_ir[RD_LSB +: RW];
  assign w_ra     = r_ir[RA_LSB +: RW];
  assign w_rb     = r_ir[RB_LSB +: RW];
  assign w_imm    = r_ir[IMM_LSB +: DW];
  assign w_unused = r_ir[8];

  assign w_we = (r_state == WB) && !op_reserved(w_op);

  alu_sp_regfile #(
    .NREG (NREG),
    .DW   (DW)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_we       (w_we),
    .i_waddr    (w_rd),
    .i_wdata    (alu_res),
    .i_ra       (w_ra),
    .i_rb       (w_rb),
    .i_dbg_sel  (dbg_sel),
    .o_rdata_a  (w_rdata_a),
    .o_rdata_b  (w_rdata_b),
    .o_dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_next = EXEC;
        end
      end
      EXEC:    w_next = WB;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operands are captured at the end of EXEC, so rd==ra/rb sees the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir   <= '0;
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (r_state == IDLE && instr_valid) begin
        r_ir <= instr;
      end
      if (r_state == EXEC) begin
        alu_op <= {{(DW-3){1'b0}}, w_op};
        alu_a  <= (w_op == OP_LOADI) ? w_imm : w_rdata_a;
        alu_b  <= (w_op == OP_MOV || w_op == OP_LOADI) ? '0 : w_rdata_b;
      end
      if (r_state == WB) begin
        done <= 1'b1;
        err  <= op_reserved(w_op);
      end
    end
  end

`ifdef ALU_SP_SEQ_FLAGS_EN
  logic [DW:0] w_sum;

  assign w_sum = {1'b0, alu_a} + {1'b0, alu_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (w_we) begin
      zero_flag <= (alu_res == '0);
      case (w_op)
        OP_ADD:  carry_flag <= w_sum[DW];
        OP_SUB:  carry_flag <= (alu_a < alu_b);
        default: carry_flag <= 1'b0;
      endcase
    end
  end
`endif

endmodule

`default_nettype wire
